// File: rtl/funct_generator_amp_scaler.sv
// Scales offset-binary waveform samples about midscale by a Q4.4 amplitude latched at period starts.
// Define FG_AMP_CLIP_CNT_EN to add the saturating clip_count output.
module funct_generator_amp_scaler #(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   AMP_WIDTH  = 8,
  parameter int                   AMP_FRAC   = 4,
  parameter logic [AMP_WIDTH-1:0] AMP_RESET  = 8'h10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clrh,
  input  logic                  enh,
  input  logic [AMP_WIDTH-1:0]  amp,
  input  logic [DATA_WIDTH-1:0] in_sample,
  input  logic                  in_sof,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_sample,
  output logic                  out_sof,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_clip
`ifdef FG_AMP_CLIP_CNT_EN
  ,
  output logic [15:0]           clip_count
`endif
);

  localparam int STAGES = 2;
  localparam int PROD_W = DATA_WIDTH + AMP_WIDTH + 1;
  localparam logic signed [PROD_W-1:0] RES_MID = PROD_W'(1 << (DATA_WIDTH - 1));
  localparam logic signed [PROD_W-1:0] RES_MAX = PROD_W'((1 << DATA_WIDTH) - 1);
  localparam logic [DATA_WIDTH-1:0]    MID     = DATA_WIDTH'(1 << (DATA_WIDTH - 1));

  logic                     adv;
  logic [STAGES:1]          vld_pipe_q;
  logic [AMP_WIDTH-1:0]     shadow_q;
  logic signed [PROD_W-1:0] s1_prod_q;
  logic                     s1_sof_q;
  logic [DATA_WIDTH-1:0]    out_sample_q;
  logic                     out_sof_q;
  logic                     out_clip_q;

  // clrh suppresses acceptance so a sample offered during the clear is not lost silently
  assign adv      = enh & ~clrh & (~vld_pipe_q[STAGES] | out_ready);
  assign in_ready = adv;

  // Stage 1: signed excursion times the effective gain
  logic signed [DATA_WIDTH:0]  diff;
  logic [AMP_WIDTH-1:0]        gain;
  logic signed [PROD_W-1:0]    prod_d;

  assign diff   = $signed({1'b0, in_sample}) - $signed({1'b0, MID});
  assign gain   = in_sof ? amp : shadow_q;
  assign prod_d = PROD_W'(diff) * PROD_W'($signed({1'b0, gain}));

  // Stage 2: drop the fraction (floor) and saturate back to the sample range
  logic signed [PROD_W-1:0] res;
  logic [DATA_WIDTH-1:0]    sat_d;
  logic                     clip_d;

  assign res = (s1_prod_q >>> AMP_FRAC) + RES_MID;

  always_comb begin
    sat_d  = res[DATA_WIDTH-1:0];
    clip_d = 1'b0;
    if (res[PROD_W-1]) begin
      sat_d  = '0;
      clip_d = 1'b1;
    end else if (res > RES_MAX) begin
      sat_d  = '1;
      clip_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe_q   <= '0;
      shadow_q     <= AMP_RESET;
      s1_prod_q    <= '0;
      s1_sof_q     <= 1'b0;
      out_sample_q <= MID;
      out_sof_q    <= 1'b0;
      out_clip_q   <= 1'b0;
    end else if (clrh) begin
      vld_pipe_q   <= '0;
      shadow_q     <= AMP_RESET;
      s1_prod_q    <= '0;
      s1_sof_q     <= 1'b0;
      out_sample_q <= MID;
      out_sof_q    <= 1'b0;
      out_clip_q   <= 1'b0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], in_valid};
      if (in_valid) begin
        s1_prod_q <= prod_d;
        s1_sof_q  <= in_sof;
        if (in_sof) shadow_q <= amp;
      end
      // bubbles leave the output data and clip flag untouched
      if (vld_pipe_q[1]) begin
        out_sample_q <= sat_d;
        out_sof_q    <= s1_sof_q;
        out_clip_q   <= clip_d;
      end
    end
  end

  assign out_valid  = vld_pipe_q[STAGES];
  assign out_sample = out_sample_q;
  assign out_sof    = out_sof_q;
  assign out_clip   = out_clip_q;

`ifdef FG_AMP_CLIP_CNT_EN
  logic [15:0] clip_cnt_q;

  // counted on the transfer itself, so a sample frozen by enh=0 is counted once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clip_cnt_q <= '0;
    end else if (clrh) begin
      clip_cnt_q <= '0;
    end else if (adv && vld_pipe_q[STAGES] && out_clip_q && clip_cnt_q != 16'hFFFF) begin
      clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end

  assign clip_count = clip_cnt_q;
`endif

endmodule
